mdu_iter: RTL and testbench
===========================

Name: mdu_iter

Overview:
- Parametrised iterative multiply/divide unit implementing the RV32M op set (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU); multi-cycle successor to the combinational ALU.
- Sits beside the ALU in the execute stage; the core stalls on MDU_Busy and consumes the result on MDU_Done.
- Radix-2 shift-add multiply and restoring divide; one bit per cycle; start/busy/done handshake.

Parameters:
- DWIDTH, 32, operand/result width in bits (even, >= 4)
- CNT_W, $clog2(DWIDTH)+1, iteration counter width (derived, not overridden)

Ports:
- Clk  input  1  core clock, rising edge
- Rst_N  input  1  asynchronous active-low reset
- MDU_Start  input  1  request; sampled only when idle
- MDU_OP  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- MDU_In_A  input  DWIDTH  rs1 operand (dividend / multiplicand)
- MDU_In_B  input  DWIDTH  rs2 operand (divisor / multiplier)
- MDU_Busy  output  1  high while an operation is in flight
- MDU_Done  output  1  one-cycle pulse; result valid
- MDU_Out  output  DWIDTH  registered result, held until next accepted start
- MDU_Zero_Flag  output  1  registered (MDU_Out == 0)

Behaviour:
- Reset (async, Rst_N=0): state IDLE; MDU_Busy=0, MDU_Done=0, MDU_Out=0, MDU_Zero_Flag=1; counter and operand registers cleared. Reset mid-operation aborts with no Done pulse.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE + MDU_Start=1: latch OP and operands; take magnitudes per signedness (MULH: both signed; MULHSU: A signed, B unsigned; DIV/REM: both signed); record result sign. Go to CALC, counter=0, Busy=1. The fast paths below go directly to DONE.
- CALC: one iteration per cycle (multiply: conditional add + shift into 2*DWIDTH product; divide: shift, trial subtract, set quotient bit). Stay DWIDTH cycles, then FIX.
- FIX: apply two's-complement sign correction. Select low half (MUL), high half (MULH*), quotient (DIV*) or remainder (REM*). Write MDU_Out/Zero_Flag. Go to DONE.
- DONE: Done=1, Busy=0 for one cycle. Then IDLE, or accept a new Start in the same cycle (back-to-back).
- Normal latency: Done high in the cycle after the (DWIDTH+2)th rising edge following the edge that samples Start (DWIDTH=32: 34 edges).
- Quotient sign = sign(A) xor sign(B). Remainder sign = sign(A).
- Fast path, latency 1 edge (Done in the cycle after the sampling edge):
  - divisor zero: DIV/DIVU -> all-ones; REM/REMU -> A.
  - signed overflow (A = most negative, B = -1): DIV -> A; REM -> 0.
- MDU_Start while Busy: ignored, no effect on the in-flight operation. Operand/OP changes after the sampling edge: no effect.
- MDU_Out/Zero_Flag change only on a FIX or fast-path write.

Optional Feature:
- Macro MDU_FLUSH_EN.
- Defined: adds input port MDU_Flush (1 bit). MDU_Flush=1 in CALC or FIX returns to IDLE on the next edge: Busy=0, no Done pulse, MDU_Out unchanged. In IDLE/DONE, Flush has priority over Start; the request is dropped.
- Undefined: port absent; an operation always runs to completion.

Test Plan:
- MUL A=7, B=6 -> MDU_Out=0x0000002A, Zero=0, Done exactly 34 edges after Start, Busy high throughout.
- MULH 0x80000000*0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF.
- DIV A=0xFFFFFFF9 (-7), B=2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 0x64/0x7 -> 0x0E.
- DIVU 5/0 -> 0xFFFFFFFF and REMU 5/0 -> 0x5, both Done 1 edge after Start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0 with Zero=1.
- Start pulsed at cycle 10 of a busy MUL with new operands -> ignored, original result returned. Back-to-back Start during the DONE cycle -> accepted, second Done 34 edges later.
- Rst_N low at cycle 15 of a DIV -> Busy=0, Out=0, Zero=1 immediately, no Done pulse. With MDU_FLUSH_EN: Flush at cycle 5 -> IDLE, prior MDU_Out retained.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide, one bit per cycle; DWIDTH+2 edges per op, 1 edge for div-by-zero/overflow.
// Start is ignored while busy (no backpressure beyond MDU_Busy); MDU_FLUSH_EN adds MDU_Flush to abort in-flight ops.
module mdu_iter #(
    parameter int DWIDTH = 32
) (
    input  logic              Clk,
    input  logic              Rst_N,
`ifdef MDU_FLUSH_EN
    input  logic              MDU_Flush,
`endif
    input  logic              MDU_Start,
    input  logic [2:0]        MDU_OP,
    input  logic [DWIDTH-1:0] MDU_In_A,
    input  logic [DWIDTH-1:0] MDU_In_B,
    output logic              MDU_Busy,
    output logic              MDU_Done,
    output logic [DWIDTH-1:0] MDU_Out,
    output logic              MDU_Zero_Flag
);
    localparam int CNT_W = $clog2(DWIDTH) + 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DWIDTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [DWIDTH-1:0] MOST_NEG = {1'b1, {(DWIDTH-1){1'b0}}};

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;
    state_t state, state_nxt;

    logic flush;
`ifdef MDU_FLUSH_EN
    assign flush = MDU_Flush;
`else
    assign flush = 1'b0;
`endif

    logic [2:0]          op_q;
    logic                neg_q;
    logic [DWIDTH-1:0]   opnd;
    logic [2*DWIDTH-1:0] prod;
    logic [CNT_W-1:0]    cnt;

    // Request decode: magnitudes, result sign and the single-edge fast paths
    logic              a_sgn, b_sgn, a_neg, b_neg, res_neg, b_zero, ovf, fast;
    logic [DWIDTH-1:0] a_abs, b_abs, fast_val;

    always_comb begin
        a_sgn   = (MDU_OP == OP_MULH) || (MDU_OP == OP_MULHSU) ||
                  (MDU_OP == OP_DIV)  || (MDU_OP == OP_REM);
        b_sgn   = (MDU_OP == OP_MULH) || (MDU_OP == OP_DIV) || (MDU_OP == OP_REM);
        a_neg   = a_sgn & MDU_In_A[DWIDTH-1];
        b_neg   = b_sgn & MDU_In_B[DWIDTH-1];
        a_abs   = a_neg ? -MDU_In_A : MDU_In_A;
        b_abs   = b_neg ? -MDU_In_B : MDU_In_B;
        res_neg = (MDU_OP == OP_REM) ? a_neg : (a_neg ^ b_neg);
        b_zero  = (MDU_In_B == '0);
        ovf     = ((MDU_OP == OP_DIV) || (MDU_OP == OP_REM)) &&
                  (MDU_In_A == MOST_NEG) && (MDU_In_B == '1);
        fast    = MDU_OP[2] & (b_zero | ovf);
        if (b_zero)
            fast_val = MDU_OP[1] ? MDU_In_A : '1;
        else
            fast_val = MDU_OP[1] ? '0 : MDU_In_A;
    end

    // Iteration step: multiply shifts right through {acc, multiplier};
    // divide shifts left through {remainder, dividend/quotient}.
    logic [DWIDTH:0]     mul_sum, partial;
    logic [DWIDTH-1:0]   diff;
    logic                ge;
    logic [2*DWIDTH-1:0] prod_step;

    always_comb begin
        mul_sum = {1'b0, prod[2*DWIDTH-1:DWIDTH]} + {1'b0, (prod[0] ? opnd : '0)};
        partial = {prod[2*DWIDTH-1:DWIDTH], prod[DWIDTH-1]};
        ge      = (partial >= {1'b0, opnd});
        diff    = partial[DWIDTH-1:0] - opnd;
        if (!op_q[2])
            prod_step = {mul_sum, prod[DWIDTH-1:1]};
        else if (ge)
            prod_step = {diff, prod[DWIDTH-2:0], 1'b1};
        else
            prod_step = {partial[DWIDTH-1:0], prod[DWIDTH-2:0], 1'b0};
    end

    logic [2*DWIDTH-1:0] prod_sgn;
    logic [DWIDTH-1:0]   quo, rem, res;

    always_comb begin
        prod_sgn = neg_q ? -prod : prod;
        quo      = neg_q ? -prod[DWIDTH-1:0] : prod[DWIDTH-1:0];
        rem      = neg_q ? -prod[2*DWIDTH-1:DWIDTH] : prod[2*DWIDTH-1:DWIDTH];
        case (op_q)
            OP_MUL:                       res = prod_sgn[DWIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: res = prod_sgn[2*DWIDTH-1:DWIDTH];
            OP_DIV, OP_DIVU:              res = quo;
            default:                      res = rem;
        endcase
    end

    logic accept, fix_wr;

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        fix_wr    = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                state_nxt = S_IDLE;
                if (!flush && MDU_Start) begin
                    accept    = 1'b1;
                    state_nxt = fast ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                if (flush)
                    state_nxt = S_IDLE;
                else if (cnt == CNT_LAST)
                    state_nxt = S_FIX;
            end
            S_FIX: begin
                if (flush) begin
                    state_nxt = S_IDLE;
                end else begin
                    fix_wr    = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign MDU_Busy = (state == S_CALC) || (state == S_FIX);
    assign MDU_Done = (state == S_DONE);

    always_ff @(posedge Clk or negedge Rst_N) begin
        if (!Rst_N) begin
            op_q          <= '0;
            neg_q         <= 1'b0;
            opnd          <= '0;
            prod          <= '0;
            cnt           <= '0;
            MDU_Out       <= '0;
            MDU_Zero_Flag <= 1'b1;
        end else if (accept) begin
            op_q  <= MDU_OP;
            neg_q <= res_neg;
            opnd  <= MDU_OP[2] ? b_abs : a_abs;
            prod  <= {{DWIDTH{1'b0}}, (MDU_OP[2] ? a_abs : b_abs)};
            cnt   <= '0;
            if (fast) begin
                MDU_Out       <= fast_val;
                MDU_Zero_Flag <= (fast_val == '0);
            end
        end else if (state == S_CALC) begin
            prod <= prod_step;
            cnt  <= cnt + CNT_ONE;
        end else if (fix_wr) begin
            MDU_Out       <= res;
            MDU_Zero_Flag <= (res == '0);
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: RV32M vectors, fast paths, start-while-busy, back-to-back, reset abort, optional flush.
module tb_mdu_iter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in_a, in_b;
    logic        busy, done, zero;
    logic [31:0] out;
`ifdef MDU_FLUSH_EN
    logic        flush = 1'b0;
`endif

    always #5 clk = ~clk;

    mdu_iter #(.DWIDTH(32)) dut (
        .Clk          (clk),
        .Rst_N        (rst_n),
`ifdef MDU_FLUSH_EN
        .MDU_Flush    (flush),
`endif
        .MDU_Start    (start),
        .MDU_OP       (op),
        .MDU_In_A     (in_a),
        .MDU_In_B     (in_b),
        .MDU_Busy     (busy),
        .MDU_Done     (done),
        .MDU_Out      (out),
        .MDU_Zero_Flag(zero)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive a request now; returns edges up to and including the one after which Done is seen.
    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output bit busy_ok);
        op = o; in_a = a; in_b = b; start = 1'b1;
        lat = 0; busy_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && lat < 200);
    endtask

    task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_out,
                         input int exp_lat, input logic exp_zero);
        int lat;
        bit bok;
        @(negedge clk);
        run(o, a, b, lat, bok);
        chk({tag, " out"}, out, exp_out);
        chk({tag, " zero"}, 32'(zero), 32'(exp_zero));
        chk({tag, " latency"}, lat, exp_lat);
        chk({tag, " busy_until_done"}, 32'(bok), 32'd1);
        chk({tag, " busy_in_done"}, 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int lat;
        int dn;
        bit bok;
        rst_n = 1'b0; start = 1'b0; op = 3'b000; in_a = '0; in_b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset out", out, 32'h0);
        chk("reset zero", 32'(zero), 32'd1);
        rst_n = 1'b1;

        do_op("mul 7*6",       3'b000, 32'd7,        32'd6,        32'h0000002A, 34, 1'b0);
        do_op("mul -3*5",      3'b000, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFF1, 34, 1'b0);
        do_op("mulh min*min",  3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34, 1'b0);
        do_op("mulh -1*-1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 34, 1'b1);
        do_op("mulhu max*max", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34, 1'b0);
        do_op("mulhsu -1*2",   3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 34, 1'b0);
        do_op("div -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);
        do_op("rem -7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
        do_op("div 7/-2",      3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b0);
        do_op("rem 7/-2",      3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 34, 1'b0);
        do_op("divu 100/7",    3'b101, 32'd100,      32'd7,        32'h0000000E, 34, 1'b0);
        do_op("remu 100/7",    3'b111, 32'd100,      32'd7,        32'h00000002, 34, 1'b0);
        do_op("divu 5/0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  1'b0);
        do_op("remu 5/0",      3'b111, 32'd5,        32'd0,        32'h00000005, 1,  1'b0);
        do_op("div ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
        do_op("rem ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1,  1'b1);

        // Start pulsed mid-operation with different operands must be ignored
        @(negedge clk);
        op = 3'b000; in_a = 32'd7; in_b = 32'd6; start = 1'b1;
        lat = 0; bok = 1'b1;
        do begin
            @(posedge clk); #1;
            lat++;
            start = (lat == 10);
            if (lat == 10) begin op = 3'b000; in_a = 32'd3; in_b = 32'd3; end
            if (!done && !busy) bok = 1'b0;
        end while (!done && lat < 200);
        chk("ignore-start out", out, 32'h0000002A);
        chk("ignore-start latency", lat, 34);
        chk("ignore-start busy", 32'(bok), 32'd1);

        // Back-to-back: second request presented during the Done cycle
        @(posedge clk); #1;
        @(negedge clk);
        run(3'b000, 32'd5, 32'd5, lat, bok);
        chk("b2b first out", out, 32'h00000019);
        run(3'b101, 32'd100, 32'd7, lat, bok);
        chk("b2b second out", out, 32'h0000000E);
        chk("b2b second latency", lat, 34);
        chk("b2b second busy", 32'(bok), 32'd1);
        @(posedge clk); #1;

        // Reset asserted mid-divide aborts with no Done pulse
        @(negedge clk);
        op = 3'b100; in_a = 32'hFFFFFF9C; in_b = 32'd7; start = 1'b1;
        dn = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (done) dn++;
        end
        rst_n = 1'b0;
        #1;
        chk("mid-reset busy", 32'(busy), 32'd0);
        chk("mid-reset out", out, 32'h0);
        chk("mid-reset zero", 32'(zero), 32'd1);
        chk("mid-reset done", 32'(done), 32'd0);
        repeat (3) begin @(posedge clk); #1; if (done) dn++; end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) begin @(posedge clk); #1; if (done || busy) dn++; end
        chk("mid-reset no done", dn, 0);

`ifdef MDU_FLUSH_EN
        do_op("pre-flush mul", 3'b000, 32'd7, 32'd6, 32'h0000002A, 34, 1'b0);
        @(negedge clk);
        op = 3'b101; in_a = 32'd100; in_b = 32'd7; start = 1'b1;
        dn = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush busy", 32'(busy), 32'd0);
        chk("flush out kept", out, 32'h0000002A);
        repeat (40) begin @(posedge clk); #1; if (done || busy) dn++; end
        chk("flush no done", dn, 0);
        @(negedge clk);
        start = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        chk("flush over start busy", 32'(busy), 32'd0);
        chk("flush over start done", 32'(done), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
